// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants (640x480@60 defaults), the sync bundle type and a counter width check.
package vga_timing_pkg;

   localparam int unsigned DEF_H_ACTIVE = 640;
   localparam int unsigned DEF_H_FP     = 16;
   localparam int unsigned DEF_H_SYNC   = 96;
   localparam int unsigned DEF_H_BP     = 48;
   localparam int unsigned DEF_V_ACTIVE = 480;
   localparam int unsigned DEF_V_FP     = 10;
   localparam int unsigned DEF_V_SYNC   = 2;
   localparam int unsigned DEF_V_BP     = 33;

   localparam int unsigned DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
   localparam int unsigned DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
   localparam int unsigned DEF_CNT_W   = (DEF_H_TOTAL > DEF_V_TOTAL) ? $clog2(DEF_H_TOTAL)
                                                                     : $clog2(DEF_V_TOTAL);

   typedef struct packed {
      logic hs;
      logic vs;
      logic de;
   } sync_t;

   localparam int unsigned SYNC_W = $bits(sync_t);

   // True when a cnt_w-bit counter can reach both h_total-1 and v_total-1.
   function automatic bit cnt_w_fits(input int unsigned cnt_w, input int unsigned h_total,
                                     input int unsigned v_total);
      return ($clog2(h_total) <= cnt_w) && ($clog2(v_total) <= cnt_w);
   endfunction

endpackage

// File: rtl/vga_delay_line.sv
// WIDTH x DEPTH shift register advancing only when i_en is high; async active-high reset to 0.
module vga_delay_line #(
   parameter int unsigned WIDTH = 1,
   parameter int unsigned DEPTH = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_en,
   input  logic [WIDTH-1:0] i_data,
   output logic [WIDTH-1:0] o_data
);

   logic [WIDTH-1:0] r_stage [DEPTH];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
      end else if (i_en) begin
         r_stage[0] <= i_data;
         for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
      end
   end

   assign o_data = r_stage[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: h/v counters, registered coordinates and strobes, and a pin stage
// whose sync/DE are delayed PIPE_LAT ticks to line up with the host's registered colour path.
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
   parameter int unsigned H_FP     = DEF_H_FP,
   parameter int unsigned H_SYNC   = DEF_H_SYNC,
   parameter int unsigned H_BP     = DEF_H_BP,
   parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
   parameter int unsigned V_FP     = DEF_V_FP,
   parameter int unsigned V_SYNC   = DEF_V_SYNC,
   parameter int unsigned V_BP     = DEF_V_BP,
   parameter int unsigned HS_POL   = 0,
   parameter int unsigned VS_POL   = 0,
   parameter int unsigned COLOR_W  = 4,
   parameter int unsigned PIPE_LAT = 1,
   parameter int unsigned CNT_W    = DEF_CNT_W
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               pix_ce,
   input  logic [COLOR_W-1:0] i_red,
   input  logic [COLOR_W-1:0] i_green,
   input  logic [COLOR_W-1:0] i_blue,
   output logic [CNT_W-1:0]   x_cor,
   output logic [CNT_W-1:0]   y_cor,
   output logic               coord_valid,
   output logic               line_start,
   output logic               frame_start,
   output logic               hsync,
   output logic               vsync,
   output logic               de,
   output logic [COLOR_W-1:0] red,
   output logic [COLOR_W-1:0] green,
   output logic [COLOR_W-1:0] blue
);

   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [CNT_W-1:0] L_H_LAST    = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] L_V_LAST    = CNT_W'(V_TOTAL - 1);
   localparam logic [CNT_W-1:0] L_H_ACT     = CNT_W'(H_ACTIVE);
   localparam logic [CNT_W-1:0] L_V_ACT     = CNT_W'(V_ACTIVE);
   localparam logic [CNT_W-1:0] L_HS_FIRST  = CNT_W'(H_ACTIVE + H_FP);
   localparam logic [CNT_W-1:0] L_HS_LAST   = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [CNT_W-1:0] L_VS_FIRST  = CNT_W'(V_ACTIVE + V_FP);
   localparam logic [CNT_W-1:0] L_VS_LAST   = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);
   localparam logic             L_HS_IDLE   = (HS_POL == 0) ? 1'b1 : 1'b0;
   localparam logic             L_VS_IDLE   = (VS_POL == 0) ? 1'b1 : 1'b0;

   if (!cnt_w_fits(CNT_W, H_TOTAL, V_TOTAL)) begin : g_bad_cnt_w
      $error("vga_timing_gen: CNT_W cannot hold H_TOTAL-1/V_TOTAL-1");
   end
   if (PIPE_LAT < 1 || PIPE_LAT > 8) begin : g_bad_pipe_lat
      $error("vga_timing_gen: PIPE_LAT must be 1..8");
   end

   // S0: raster counters
   logic [CNT_W-1:0] r_h;
   logic [CNT_W-1:0] r_v;
   logic             w_h_last;
   logic             w_v_last;

   assign w_h_last = (r_h == L_H_LAST);
   assign w_v_last = (r_v == L_V_LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_h <= '0;
         r_v <= '0;
      end else if (pix_ce) begin
         if (w_h_last) begin
            r_h <= '0;
            r_v <= w_v_last ? '0 : r_v + 1'b1;
         end else begin
            r_h <= r_h + 1'b1;
         end
      end
   end

   // S1: coordinates, raw sync/DE and strobes
   logic             w_h_act;
   logic             w_v_act;
   logic             w_hs_raw;
   logic             w_vs_raw;
   logic [CNT_W-1:0] r_x;
   logic [CNT_W-1:0] r_y;
   logic             r_cv;
   logic             r_hs;
   logic             r_vs;
   logic             r_line_start;
   logic             r_frame_start;

   assign w_h_act  = (r_h < L_H_ACT);
   assign w_v_act  = (r_v < L_V_ACT);
   assign w_hs_raw = (r_h >= L_HS_FIRST) && (r_h <= L_HS_LAST);
   // v only moves on the h wrap, so this can only change at h=0
   assign w_vs_raw = (r_v >= L_VS_FIRST) && (r_v <= L_VS_LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_x           <= '0;
         r_y           <= '0;
         r_cv          <= 1'b0;
         r_hs          <= 1'b0;
         r_vs          <= 1'b0;
         r_line_start  <= 1'b0;
         r_frame_start <= 1'b0;
      end else begin
         // Strobes are rewritten every clk so they stay one clk wide even with pix_ce gaps.
         r_line_start  <= pix_ce && (r_h == '0) && w_v_act;
         r_frame_start <= pix_ce && (r_h == '0) && (r_v == '0);
         if (pix_ce) begin
            r_x  <= r_h;
            r_y  <= r_v;
            r_cv <= w_h_act && w_v_act;
            r_hs <= w_hs_raw;
            r_vs <= w_vs_raw;
         end
      end
   end

   // Sync/DE delay matching the host colour latency
   sync_t w_raw;
   sync_t w_dly;

   assign w_raw = '{hs: r_hs, vs: r_vs, de: r_cv};

   vga_delay_line #(
      .WIDTH (SYNC_W),
      .DEPTH (PIPE_LAT)
   ) u_sync_dly (
      .clk    (clk),
      .reset  (reset),
      .i_en   (pix_ce),
      .i_data (w_raw),
      .o_data (w_dly)
   );

   // Pin registers
   logic               r_hsync;
   logic               r_vsync;
   logic               r_de;
   logic [COLOR_W-1:0] r_red;
   logic [COLOR_W-1:0] r_green;
   logic [COLOR_W-1:0] r_blue;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_hsync <= L_HS_IDLE;
         r_vsync <= L_VS_IDLE;
         r_de    <= 1'b0;
         r_red   <= '0;
         r_green <= '0;
         r_blue  <= '0;
      end else if (pix_ce) begin
         r_hsync <= w_dly.hs ^ L_HS_IDLE;
         r_vsync <= w_dly.vs ^ L_VS_IDLE;
         r_de    <= w_dly.de;
         r_red   <= w_dly.de ? i_red   : '0;
         r_green <= w_dly.de ? i_green : '0;
         r_blue  <= w_dly.de ? i_blue  : '0;
      end
   end

   assign x_cor       = r_x;
   assign y_cor       = r_y;
   assign coord_valid = r_cv;
   assign line_start  = r_line_start;
   assign frame_start = r_frame_start;
   assign hsync       = r_hsync;
   assign vsync       = r_vsync;
   assign de          = r_de;
   assign red         = r_red;
   assign green       = r_green;
   assign blue        = r_blue;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default mode, PIPE_LAT=3 mode and a tiny mode, all checked every cycle
// against a tick-count arithmetic model, plus a checkpoint table and hand-written corner sequences.
module tb_vga_timing_gen;

   typedef struct {
      int ha, hfp, hsw, hbp, va, vfp, vsw, vbp, hpol, vpol, lat;
   } mode_t;

   typedef struct {
      int n;
      int x;
      int y;
      bit cv;
      bit hs;
      bit vs;
      bit de;
   } vec_t;

   logic       clk = 1'b0;
   logic       reset;
   logic       pix_ce;
   logic [3:0] red_def, red_l3, red_sm, green_in, blue_in;

   logic [9:0] d_x, d_y, l_x, l_y;
   logic [3:0] s_x, s_y;
   logic       d_cv, d_ls, d_fs, d_hs, d_vs, d_de;
   logic       l_cv, l_ls, l_fs, l_hs, l_vs, l_de;
   logic       s_cv, s_ls, s_fs, s_hs, s_vs, s_de;
   logic [3:0] d_r, d_g, d_b, l_r, l_g, l_b, s_r, s_g, s_b;

   mode_t m_def, m_l3, m_sm;
   int    ticks     = 0;
   bit    last_tick = 0;
   logic [3:0] g_tick = '0;
   int    n_chk  = 0;
   int    n_pass = 0;
   vec_t  tbl[14];

   always #5 clk = ~clk;

   vga_timing_gen u_def (
      .clk(clk), .reset(reset), .pix_ce(pix_ce),
      .i_red(red_def), .i_green(green_in), .i_blue(blue_in),
      .x_cor(d_x), .y_cor(d_y), .coord_valid(d_cv), .line_start(d_ls), .frame_start(d_fs),
      .hsync(d_hs), .vsync(d_vs), .de(d_de), .red(d_r), .green(d_g), .blue(d_b)
   );

   vga_timing_gen #(.PIPE_LAT(3)) u_l3 (
      .clk(clk), .reset(reset), .pix_ce(pix_ce),
      .i_red(red_l3), .i_green(green_in), .i_blue(blue_in),
      .x_cor(l_x), .y_cor(l_y), .coord_valid(l_cv), .line_start(l_ls), .frame_start(l_fs),
      .hsync(l_hs), .vsync(l_vs), .de(l_de), .red(l_r), .green(l_g), .blue(l_b)
   );

   vga_timing_gen #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
      .HS_POL(1), .VS_POL(1), .PIPE_LAT(1), .CNT_W(4)
   ) u_sm (
      .clk(clk), .reset(reset), .pix_ce(pix_ce),
      .i_red(red_sm), .i_green(green_in), .i_blue(blue_in),
      .x_cor(s_x), .y_cor(s_y), .coord_valid(s_cv), .line_start(s_ls), .frame_start(s_fs),
      .hsync(s_hs), .vsync(s_vs), .de(s_de), .red(s_r), .green(s_g), .blue(s_b)
   );

   task automatic chk(input string nm, input string what, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s %s: got %0h expected %0h", nm, what, act, exp);
   endtask

   // Raster position of the c-th coordinate issued since reset.
   function automatic void model_xy(input mode_t m, input int c, output int x, output int y);
      int ht, vt, p;
      ht = m.ha + m.hfp + m.hsw + m.hbp;
      vt = m.va + m.vfp + m.vsw + m.vbp;
      p  = c % (ht * vt);
      x  = p % ht;
      y  = p / ht;
   endfunction

   // Host renderer: colour for the coordinate that reaches the pins on tick t_next.
   function automatic logic [3:0] host_red(input mode_t m, input int t_next);
      int c, x, y;
      c = t_next - 2 - m.lat;
      if (c < 0) return 4'hF;
      model_xy(m, c, x, y);
      return (x < m.ha && y < m.va) ? 4'(x) : 4'hF;
   endfunction

   task automatic check_dut(input string nm, input mode_t m, input logic [31:0] ax,
                            input logic [31:0] ay, input logic acv, input logic als,
                            input logic afs, input logic ahs, input logic avs, input logic ade,
                            input logic [3:0] ar, input logic [3:0] ag, input logic [3:0] ab);
      int x, y, px, py, c;
      bit cv, fs, ls, hs, vs, de;
      logic [3:0] er, eg, eb;
      x = 0; y = 0; cv = 0; fs = 0; ls = 0;
      if (ticks > 0) begin
         model_xy(m, ticks - 1, x, y);
         cv = (x < m.ha) && (y < m.va);
         fs = last_tick && x == 0 && y == 0;
         ls = last_tick && x == 0 && y < m.va;
      end
      hs = (m.hpol == 0); vs = (m.vpol == 0); de = 0; er = '0; eg = '0; eb = '0;
      c = ticks - 2 - m.lat;
      if (c >= 0) begin
         model_xy(m, c, px, py);
         de = (px < m.ha) && (py < m.va);
         if (px >= m.ha + m.hfp && px < m.ha + m.hfp + m.hsw) hs = (m.hpol != 0);
         if (py >= m.va + m.vfp && py < m.va + m.vfp + m.vsw) vs = (m.vpol != 0);
         if (de) begin
            er = 4'(px); eg = g_tick; eb = ~g_tick;
         end
      end
      chk(nm, "x_cor", ax, 32'(x));
      chk(nm, "y_cor", ay, 32'(y));
      chk(nm, "coord_valid", 32'(acv), 32'(cv));
      chk(nm, "frame_start", 32'(afs), 32'(fs));
      chk(nm, "line_start", 32'(als), 32'(ls));
      chk(nm, "hsync", 32'(ahs), 32'(hs));
      chk(nm, "vsync", 32'(avs), 32'(vs));
      chk(nm, "de", 32'(ade), 32'(de));
      chk(nm, "red", 32'(ar), 32'(er));
      chk(nm, "green", 32'(ag), 32'(eg));
      chk(nm, "blue", 32'(ab), 32'(eb));
   endtask

   task automatic check_all();
      check_dut("def", m_def, 32'(d_x), 32'(d_y), d_cv, d_ls, d_fs, d_hs, d_vs, d_de,
                d_r, d_g, d_b);
      check_dut("lat3", m_l3, 32'(l_x), 32'(l_y), l_cv, l_ls, l_fs, l_hs, l_vs, l_de,
                l_r, l_g, l_b);
      check_dut("small", m_sm, 32'(s_x), 32'(s_y), s_cv, s_ls, s_fs, s_hs, s_vs, s_de,
                s_r, s_g, s_b);
   endtask

   // One clk, entered and left at the falling edge.
   task automatic step(input bit ce);
      pix_ce   = ce;
      red_def  = host_red(m_def, ticks + 1);
      red_l3   = host_red(m_l3, ticks + 1);
      red_sm   = host_red(m_sm, ticks + 1);
      green_in = 4'($urandom);
      blue_in  = ~green_in;
      @(posedge clk);
      if (reset) begin
         ticks = 0; last_tick = 0;
      end else begin
         last_tick = ce;
         if (ce) begin
            ticks++; g_tick = green_in;
         end
      end
      @(negedge clk);
      check_all();
   endtask

   initial begin
      int cnt;
      bit ce;
      m_def = '{640, 16, 96, 48, 480, 10, 2, 33, 0, 0, 1};
      m_l3  = '{640, 16, 96, 48, 480, 10, 2, 33, 0, 0, 3};
      m_sm  = '{8, 2, 3, 3, 4, 1, 2, 1, 1, 1, 1};
      tbl[0]  = '{0,   0,  0, 0, 0, 0, 0};
      tbl[1]  = '{1,   0,  0, 1, 0, 0, 0};
      tbl[2]  = '{2,   1,  0, 1, 0, 0, 0};
      tbl[3]  = '{3,   2,  0, 1, 0, 0, 1};
      tbl[4]  = '{13,  12, 0, 0, 1, 0, 0};
      tbl[5]  = '{16,  15, 0, 0, 0, 0, 0};
      tbl[6]  = '{17,  0,  1, 1, 0, 0, 0};
      tbl[7]  = '{56,  7,  3, 1, 0, 0, 1};
      tbl[8]  = '{83,  2,  5, 0, 0, 1, 0};
      tbl[9]  = '{100, 3,  6, 0, 0, 1, 0};
      tbl[10] = '{113, 0,  7, 0, 0, 1, 0};
      tbl[11] = '{115, 2,  7, 0, 0, 0, 0};
      tbl[12] = '{129, 0,  0, 1, 0, 0, 0};
      tbl[13] = '{131, 2,  0, 1, 0, 0, 1};

      reset = 1'b0; pix_ce = 1'b0;
      red_def = '0; red_l3 = '0; red_sm = '0; green_in = '0; blue_in = '0;
      #1 reset = 1'b1;
      @(negedge clk);
      repeat (3) step(1'b0);
      reset = 1'b0;

      // Checkpoint table for the tiny mode, pix_ce held high from reset release
      for (int i = 0; i < 14; i++) begin
         cnt = 0;
         while (ticks < tbl[i].n && cnt < 1000) begin
            step(1'b1); cnt++;
         end
         chk($sformatf("tbl%0d", i), "x_cor", 32'(s_x), 32'(tbl[i].x));
         chk($sformatf("tbl%0d", i), "y_cor", 32'(s_y), 32'(tbl[i].y));
         chk($sformatf("tbl%0d", i), "coord_valid", 32'(s_cv), 32'(tbl[i].cv));
         chk($sformatf("tbl%0d", i), "hsync", 32'(s_hs), 32'(tbl[i].hs));
         chk($sformatf("tbl%0d", i), "vsync", 32'(s_vs), 32'(tbl[i].vs));
         chk($sformatf("tbl%0d", i), "de", 32'(s_de), 32'(tbl[i].de));
      end

      // Default mode: line_start to hsync assertion, hsync width
      cnt = 0;
      while (d_ls !== 1'b1 && cnt < 1000) begin step(1'b1); cnt++; end
      chk("def", "line_start_seen", 32'(d_ls), 32'd1);
      cnt = 0;
      while (d_hs !== 1'b0 && cnt < 1000) begin step(1'b1); cnt++; end
      chk("def", "line_start_to_hsync", 32'(cnt), 32'd658);
      cnt = 0;
      while (d_hs === 1'b0 && cnt < 200) begin step(1'b1); cnt++; end
      chk("def", "hsync_width", 32'(cnt), 32'd96);

      // PIPE_LAT=3: de high 640 ticks per line
      cnt = 0;
      while (l_de !== 1'b1 && cnt < 1000) begin step(1'b1); cnt++; end
      chk("lat3", "de_rise_seen", 32'(l_de), 32'd1);
      chk("lat3", "red_at_de_rise", 32'(l_r), 32'd0);
      cnt = 0;
      while (l_de === 1'b1 && cnt < 1000) begin step(1'b1); cnt++; end
      chk("lat3", "de_width", 32'(cnt), 32'd640);

      // Tiny mode frame_start period with pix_ce=1
      cnt = 0;
      while (s_fs !== 1'b1 && cnt < 300) begin step(1'b1); cnt++; end
      chk("small", "fs_seen", 32'(s_fs), 32'd1);
      cnt = 0;
      do begin step(1'b1); cnt++; end while (s_fs !== 1'b1 && cnt < 300);
      chk("small", "fs_period_ce1", 32'(cnt), 32'd128);

      // Random pix_ce
      for (int i = 0; i < 3000; i++) step(1'($urandom_range(0, 1)));

      // pix_ce 1010: frame period doubles, strobe stays one clk
      ce = 1'b1; cnt = 0;
      while (s_fs !== 1'b1 && cnt < 600) begin step(ce); ce = ~ce; cnt++; end
      chk("small", "fs_seen_1010", 32'(s_fs), 32'd1);
      step(ce); ce = ~ce;
      chk("small", "fs_width_1010", 32'(s_fs), 32'd0);
      cnt = 1;
      while (s_fs !== 1'b1 && cnt < 600) begin step(ce); ce = ~ce; cnt++; end
      chk("small", "fs_period_1010", 32'(cnt), 32'd256);

      // Asynchronous reset mid-frame
      cnt = 0;
      while (!(s_x === 4'd5 && s_y === 4'd2) && cnt < 300) begin step(1'b1); cnt++; end
      chk("small", "reached_5_2", 32'({s_y, s_x}), 32'h25);
      #2 reset = 1'b1;
      #1;
      chk("rst_async", "def_hsync", 32'(d_hs), 32'd1);
      chk("rst_async", "def_vsync", 32'(d_vs), 32'd1);
      chk("rst_async", "def_de", 32'(d_de), 32'd0);
      chk("rst_async", "def_red", 32'(d_r), 32'd0);
      chk("rst_async", "lat3_x", 32'(l_x), 32'd0);
      chk("rst_async", "small_hsync", 32'(s_hs), 32'd0);
      chk("rst_async", "small_vsync", 32'(s_vs), 32'd0);
      chk("rst_async", "small_de", 32'(s_de), 32'd0);
      chk("rst_async", "small_green", 32'(s_g), 32'd0);
      chk("rst_async", "small_x", 32'(s_x), 32'd0);
      @(negedge clk);
      ticks = 0; last_tick = 0;
      check_all();
      reset = 1'b0;
      step(1'b1);
      chk("rst_release", "small_fs", 32'(s_fs), 32'd1);
      chk("rst_release", "def_fs", 32'(d_fs), 32'd1);
      chk("rst_release", "small_x", 32'(s_x), 32'd0);
      step(1'b1);
      chk("rst_release", "small_x_next", 32'(s_x), 32'd1);
      repeat (300) step(1'b1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
